// File: rtl/arbiter_capture_interface.sv
// Packs the arbiter's VC grant stream into a DEPTH-entry word and keeps per-VC grant counts.
// Write latency is 1 cycle. There is no backpressure: arbiter_valid_i=0 or enb_i=0 stalls the capture.
module arbiter_capture_interface #(
    parameter int DEPTH = 64,
    parameter int SEL_W = 2,
    parameter int CNT_W = 7
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enb_i,
    input  logic                            init_i,
    input  logic [SEL_W-1:0]                arbiter_output_i,
    input  logic                            arbiter_valid_i,
    output logic [DEPTH*SEL_W-1:0]          captured_output_o,
    output logic [(1<<SEL_W)*CNT_W-1:0]     vc_counts_o,
    output logic                            busy_o,
    output logic                            done_o
);
    localparam int NUM_VC = 1 << SEL_W;
    localparam int IDX_W  = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_e;
    typedef logic [DEPTH-1:0][SEL_W-1:0]  capture_t;
    typedef logic [NUM_VC-1:0][CNT_W-1:0] counts_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    capture_t         cap_q, cap_d;
    counts_t          cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        if (enb_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (init_i) begin
                        state_d = S_CAPTURE;
                        idx_d   = '0;
                        cap_d   = '0;
                        cnt_d   = '0;
                    end
                end
                S_CAPTURE: begin
                    // A restart wins over the sample presented in the same cycle.
                    if (init_i) begin
                        idx_d = '0;
                        cap_d = '0;
                        cnt_d = '0;
                    end else if (arbiter_valid_i) begin
                        cap_d[idx_q[IDX_W-2:0]]  = arbiter_output_i;
                        cnt_d[arbiter_output_i] = cnt_q[arbiter_output_i] + CNT_W'(1);
                        idx_d                   = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(DEPTH - 1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    assign captured_output_o = cap_q;
    assign vc_counts_o       = cnt_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;

endmodule
